pkt_loss_scheduler: RTL and testbench
=====================================

Name: pkt_loss_scheduler

Overview:
Per-direction drop-decision controller for the transport-subsystem verification fabric; instantiated once per link direction (A->B, B->A) in the loss-injection path between two ports. It tracks packet boundaries on a valid/ready/start/last stream and decides per packet whether to forward or silently drop it. Policy is runtime-selectable: off, periodic, burst or pseudo-random. It exports packet and drop statistics for testbench scoreboards.

Parameters:
HEAD_W, `PKT_HEAD_WIDTH, header bus width
DATA_W, `PKT_DATA_WIDTH, data bus width
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
i_in_valid  in  1  upstream beat valid
iv_in_head  in  HEAD_W  upstream header
iv_in_data  in  DATA_W  upstream data
i_in_start  in  1  first beat of packet
i_in_last  in  1  last beat of packet
o_in_ready  out  1  upstream ready
o_out_valid  out  1  downstream beat valid
ov_out_head  out  HEAD_W  downstream header
ov_out_data  out  DATA_W  downstream data
o_out_start  out  1  downstream first beat
o_out_last  out  1  downstream last beat
i_out_ready  in  1  downstream ready
i_cfg_load  in  1  pulse: latch cfg inputs into shadow regs, clear counters, seed LFSR
iv_cfg_mode  in  2  0 OFF, 1 PERIODIC, 2 BURST, 3 RANDOM
iv_cfg_period  in  16  PERIODIC: drop 1 of every N; BURST: pass N, then drop burst
iv_cfg_burst  in  8  BURST: consecutive drops per cycle
iv_cfg_thresh  in  16  RANDOM: drop when lfsr < thresh
iv_cfg_seed  in  16  LFSR seed; 0 replaced by 16'hACE1
ov_pkt_total  out  CNT_W  packets accepted since load/reset
ov_pkt_dropped  out  CNT_W  packets dropped since load/reset
o_dropping  out  1  current beat being discarded

Behaviour:
- Zero-latency combinational datapath; no data buffering. Drop decision is the only state on the beat path.
- FSM: IDLE, PASS, DROP. Reset -> IDLE, shadow mode OFF, all counters 0, LFSR 16'hACE1.
- drop_now (IDLE only): from shadow cfg and counters, per mode rules below.
- Effective drop = (IDLE & valid & start & drop_now) | (DROP) | (IDLE & valid & ~start).
- Pass beat: o_out_* = i_in_*, o_in_ready = i_out_ready.
- Drop beat: o_out_valid = 0, o_out_start = 0, o_out_last = 0, head/data = 0, o_in_ready = 1, o_dropping = 1.
- Pkt accept event = IDLE & i_in_valid & i_in_start & o_in_ready. On accept, IDLE -> PASS or DROP unless i_in_last is also set (single-beat packet: remain IDLE).
- PASS/DROP -> IDLE on i_in_valid & i_in_last & o_in_ready.
- Orphan beat (valid without start in IDLE, e.g. after rst mid-packet): discarded, not counted.
- PERIODIC: pcnt 0..N-1 increments per accept and wraps at N-1; drop when pcnt == N-1; N = 0 never drops.
- BURST: phase counter runs 0..N+B-1; drop when phase >= N; N = 0 drops every packet when B > 0; B = 0 never drops.
- RANDOM: 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, advances once per accept. Decision uses the pre-advance value. thresh = 0 never drops.
- OFF: never drop. Counters still count ov_pkt_total.
- Statistics: ov_pkt_total +1 per accept; ov_pkt_dropped +1 per accept with drop_now. Both saturate at all-ones.
- i_cfg_load: new shadow values are used from the next cycle. Load has priority over same-cycle counter/LFSR updates; the packet accepted in that cycle is decided with old config and not counted. FSM state is unaffected, so an in-flight packet finishes under its original decision.
- Downstream backpressure during PASS stalls upstream only. Decision never changes mid-packet.

Decomposition:
- Shared package pkt_loss_def.vh: mode encodings, LFSR default seed 16'hACE1, tap mask, state encodings.
- Sub-module pkt_loss_lfsr16: load/seed/advance ports, 16-bit state out. Everything else stays in the top module.

Test Plan:
- Mode OFF, 10 three-beat packets, i_out_ready = 1 -> all 30 beats forwarded unchanged; total = 10, dropped = 0.
- PERIODIC N = 4, 12 single-beat packets -> packets 4, 8 and 12 dropped with in_ready = 1 and out_valid = 0; dropped = 3.
- BURST N = 2 B = 3, 10 packets -> pass/drop pattern P P D D D P P D D D; dropped = 6.
- RANDOM seed 16'h0000 thresh 16'h8000, 1000 packets -> LFSR starts at ACE1; drop count matches the reference-model LFSR sequence exactly.
- rst asserted on beat 2 of a 4-beat packet -> beats 3 and 4 discarded as orphans, counters 0; next packet forwarded.
- i_cfg_load in the same cycle as a start beat in PERIODIC N = 1 -> that packet dropped under old config, total stays 0; the following packet is evaluated under the new config.

Source files
------------

// File: rtl/pkt_loss_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_loss_scheduler_pkg
//  Brief    : Shared encodings, LFSR constants and config record for the
//             packet-loss scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package pkt_loss_scheduler_pkg;

    localparam int c_ST_W = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_PASS = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_DROP = 2'd2;

    localparam logic [1:0] c_MODE_OFF      = 2'd0;
    localparam logic [1:0] c_MODE_PERIODIC = 2'd1;
    localparam logic [1:0] c_MODE_BURST    = 2'd2;
    localparam logic [1:0] c_MODE_RANDOM   = 2'd3;

    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [1:0]  mode;
        logic [15:0] period;
        logic [7:0]  burst;
        logic [15:0] thresh;
    } cfg_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & c_LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_loss_scheduler_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_loss_scheduler_lfsr16
//  Brief    : 16-bit Fibonacci LFSR with seed load and single-step advance.
//  Revision : 1.0 - initial release
// ============================================================================
module pkt_loss_scheduler_lfsr16
    import pkt_loss_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [15:0] i_seed,
    input  logic        i_advance,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    // An all-zero seed would lock the register, so it falls back to the default.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_LFSR_SEED;
        end else if (i_load) begin
            r_state <= (i_seed == 16'h0000) ? c_LFSR_SEED : i_seed;
        end else if (i_advance) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/pkt_loss_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_loss_scheduler
//  Brief    : Per-packet forward/drop controller on a valid/ready/start/last
//             stream with off, periodic, burst and pseudo-random policies.
//  Revision : 1.0 - initial release
// ============================================================================
module pkt_loss_scheduler
    import pkt_loss_scheduler_pkg::*;
#(
    parameter int HEAD_W = 32,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_in_valid,
    input  logic [HEAD_W-1:0] iv_in_head,
    input  logic [DATA_W-1:0] iv_in_data,
    input  logic              i_in_start,
    input  logic              i_in_last,
    output logic              o_in_ready,
    output logic              o_out_valid,
    output logic [HEAD_W-1:0] ov_out_head,
    output logic [DATA_W-1:0] ov_out_data,
    output logic              o_out_start,
    output logic              o_out_last,
    input  logic              i_out_ready,
    input  logic              i_cfg_load,
    input  logic [1:0]        iv_cfg_mode,
    input  logic [15:0]       iv_cfg_period,
    input  logic [7:0]        iv_cfg_burst,
    input  logic [15:0]       iv_cfg_thresh,
    input  logic [15:0]       iv_cfg_seed,
    output logic [CNT_W-1:0]  ov_pkt_total,
    output logic [CNT_W-1:0]  ov_pkt_dropped,
    output logic              o_dropping
);

    cfg_t              r_cfg;
    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_nxt;
    logic [15:0]       r_pcnt;
    logic [16:0]       r_phase;
    logic [CNT_W-1:0]  r_total;
    logic [CNT_W-1:0]  r_dropped;
    logic [15:0]       w_lfsr;
    logic [16:0]       w_burst_end;
    logic              w_idle;
    logic              w_sop;
    logic              w_drop_now;
    logic              w_drop;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_lfsr_adv;

    assign w_idle      = (r_state == c_ST_IDLE);
    assign w_sop       = w_idle & i_in_valid & i_in_start;
    assign w_burst_end = {1'b0, r_cfg.period} + {9'd0, r_cfg.burst} - 17'd1;
    assign w_lfsr_adv  = w_accept & ~i_cfg_load & (r_cfg.mode == c_MODE_RANDOM);

    pkt_loss_scheduler_lfsr16 u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .i_load    (i_cfg_load),
        .i_seed    (iv_cfg_seed),
        .i_advance (w_lfsr_adv),
        .o_state   (w_lfsr)
    );

    always_comb begin
        w_drop_now = 1'b0;
        case (r_cfg.mode)
            c_MODE_PERIODIC: w_drop_now = (r_cfg.period != 16'd0) &&
                                          (r_pcnt == r_cfg.period - 16'd1);
            c_MODE_BURST:    w_drop_now = (r_cfg.burst != 8'd0) &&
                                          (r_phase >= {1'b0, r_cfg.period});
            c_MODE_RANDOM:   w_drop_now = (w_lfsr < r_cfg.thresh);
            default:         w_drop_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Beats without a start seen in IDLE are orphans of a cut packet: swallow them.
    always_comb begin
        w_state_nxt = r_state;
        w_drop      = (w_sop & w_drop_now) | (r_state == c_ST_DROP) |
                      (w_idle & i_in_valid & ~i_in_start);
        w_in_ready  = w_drop | i_out_ready;
        w_accept    = w_sop & w_in_ready;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept && !i_in_last) begin
                    w_state_nxt = w_drop_now ? c_ST_DROP : c_ST_PASS;
                end
            end
            c_ST_PASS, c_ST_DROP: begin
                if (i_in_valid && i_in_last && w_in_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Load wins over the accept in the same cycle; that packet goes uncounted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg     <= '{mode: c_MODE_OFF, period: 16'd0, burst: 8'd0, thresh: 16'd0};
            r_pcnt    <= '0;
            r_phase   <= '0;
            r_total   <= '0;
            r_dropped <= '0;
        end else if (i_cfg_load) begin
            r_cfg     <= '{mode: iv_cfg_mode, period: iv_cfg_period,
                           burst: iv_cfg_burst, thresh: iv_cfg_thresh};
            r_pcnt    <= '0;
            r_phase   <= '0;
            r_total   <= '0;
            r_dropped <= '0;
        end else if (w_accept) begin
            r_total <= r_total + {{(CNT_W-1){1'b0}}, ~&r_total};
            if (w_drop_now) begin
                r_dropped <= r_dropped + {{(CNT_W-1){1'b0}}, ~&r_dropped};
            end
            if (r_cfg.mode == c_MODE_PERIODIC) begin
                if (r_cfg.period == 16'd0 || r_pcnt == r_cfg.period - 16'd1) begin
                    r_pcnt <= '0;
                end else begin
                    r_pcnt <= r_pcnt + 16'd1;
                end
            end
            if (r_cfg.mode == c_MODE_BURST) begin
                if (r_cfg.burst == 8'd0 || r_phase >= w_burst_end) begin
                    r_phase <= '0;
                end else begin
                    r_phase <= r_phase + 17'd1;
                end
            end
        end
    end

    assign o_in_ready     = w_in_ready;
    assign o_out_valid    = i_in_valid & ~w_drop;
    assign o_out_start    = i_in_start & ~w_drop;
    assign o_out_last     = i_in_last & ~w_drop;
    assign ov_out_head    = w_drop ? '0 : iv_in_head;
    assign ov_out_data    = w_drop ? '0 : iv_in_data;
    assign o_dropping     = w_drop;
    assign ov_pkt_total   = r_total;
    assign ov_pkt_dropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_pkt_loss_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pkt_loss_scheduler
//  Brief    : Randomised self-checking bench with a packet-level loss model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_loss_scheduler;

    localparam int HW   = 8;
    localparam int DW   = 16;
    localparam int CW   = 10;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_start, in_last, out_ready, cfg_load;
    logic [HW-1:0] in_head;
    logic [DW-1:0] in_data;
    logic [1:0]    cfg_mode;
    logic [15:0]   cfg_period, cfg_thresh, cfg_seed;
    logic [7:0]    cfg_burst;
    logic          o_in_ready, o_out_valid, o_out_start, o_out_last, o_dropping;
    logic [HW-1:0] ov_out_head;
    logic [DW-1:0] ov_out_data;
    logic [CW-1:0] ov_pkt_total, ov_pkt_dropped;

    int n_checks = 0;
    int n_errors = 0;

    // Packet-level reference model: the k-th packet since load is judged directly.
    int          m_mode, m_n, m_b, m_th, m_k, m_total, m_dropped;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    pkt_loss_scheduler #(.HEAD_W(HW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .i_in_valid(in_valid), .iv_in_head(in_head), .iv_in_data(in_data),
        .i_in_start(in_start), .i_in_last(in_last), .o_in_ready(o_in_ready),
        .o_out_valid(o_out_valid), .ov_out_head(ov_out_head), .ov_out_data(ov_out_data),
        .o_out_start(o_out_start), .o_out_last(o_out_last), .i_out_ready(out_ready),
        .i_cfg_load(cfg_load), .iv_cfg_mode(cfg_mode), .iv_cfg_period(cfg_period),
        .iv_cfg_burst(cfg_burst), .iv_cfg_thresh(cfg_thresh), .iv_cfg_seed(cfg_seed),
        .ov_pkt_total(ov_pkt_total), .ov_pkt_dropped(ov_pkt_dropped), .o_dropping(o_dropping)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic bit m_peek();
        case (m_mode)
            1:       return (m_n != 0) && ((m_k % m_n) == m_n - 1);
            2:       return (m_b != 0) && ((m_k % (m_n + m_b)) >= m_n);
            3:       return int'(m_lfsr) < m_th;
            default: return 1'b0;
        endcase
    endfunction

    task automatic m_commit(input bit d);
        m_k++;
        m_lfsr  = lfsr_step(m_lfsr);
        m_total = (m_total < CMAX) ? m_total + 1 : CMAX;
        if (d) m_dropped = (m_dropped < CMAX) ? m_dropped + 1 : CMAX;
    endtask

    task automatic m_load(input int mode, input int n, input int b, input int th,
                          input logic [15:0] seed);
        m_mode = mode; m_n = n; m_b = b; m_th = th; m_k = 0;
        m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
        m_total = 0; m_dropped = 0;
    endtask

    task automatic cnt_chk(input string tag);
        chk({tag, "_total"},   64'(ov_pkt_total),   64'(m_total));
        chk({tag, "_dropped"}, 64'(ov_pkt_dropped), 64'(m_dropped));
    endtask

    task automatic beat_chk(input string tag, input bit drop);
        logic [28:0] obs, exp;
        obs = {o_out_valid, o_out_start, o_out_last, o_in_ready, o_dropping, ov_out_head, ov_out_data};
        if (drop) exp = {5'b00011, 24'h0};
        else      exp = {in_valid, in_start, in_last, out_ready, 1'b0, in_head, in_data};
        chk(tag, 64'(obs), 64'(exp));
    endtask

    task automatic do_cfg(input logic [1:0] mode, input logic [15:0] n, input logic [7:0] b,
                          input logic [15:0] th, input logic [15:0] seed);
        @(negedge clk);
        cfg_mode = mode; cfg_period = n; cfg_burst = b; cfg_thresh = th; cfg_seed = seed;
        cfg_load = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        m_load(int'(mode), int'(n), int'(b), int'(th), seed);
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    // Optional do_load pulses i_cfg_load (current cfg regs) alongside the first attempt.
    task automatic send_pkt(input int nbeats, input bit stall, input bit do_load, output bit obs_drop);
        bit pkt_drop, acc, ld;
        int tries;
        logic [HW-1:0] h;
        logic [DW-1:0] d;
        pkt_drop = 1'b0;
        obs_drop = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            h = HW'($urandom);
            d = DW'($urandom);
            acc = 1'b0;
            tries = 0;
            while (!acc) begin
                @(negedge clk);
                ld = do_load && (b == 0) && (tries == 0);
                if (b == 0) pkt_drop = m_peek();
                in_valid = 1'b1; in_start = (b == 0); in_last = (b == nbeats - 1);
                in_head = h; in_data = d;
                out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                cfg_load = ld;
                #2;
                beat_chk("beat", pkt_drop);
                acc = pkt_drop || out_ready;
                if (b == 0) obs_drop = o_dropping;
                @(posedge clk);
                if (ld) m_load(int'(cfg_mode), int'(cfg_period), int'(cfg_burst),
                               int'(cfg_thresh), cfg_seed);
                if (acc && b == 0 && !ld) m_commit(pkt_drop);
                tries++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0; cfg_load = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit        dr;
        logic [11:0] pat12;
        logic [9:0]  pat10;
        logic [1:0]  t_mode [8] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        logic [15:0] t_n    [8] = '{16'd0, 16'd3, 16'd0, 16'd3, 16'd1, 16'd0, 16'd0, 16'd5};
        logic [7:0]  t_b    [8] = '{8'd0, 8'd0, 8'd2, 8'd0, 8'd4, 8'd0, 8'd0, 8'd2};
        logic [15:0] t_th   [8] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'h0, 16'd9};

        rst = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_head = '0; in_data = '0; cfg_load = 1'b0;
        cfg_mode = 2'd0; cfg_period = '0; cfg_burst = '0; cfg_thresh = '0; cfg_seed = '0;
        m_load(0, 0, 0, 0, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        cnt_chk("reset");
        chk("reset_out_valid", 64'(o_out_valid), 64'd0);
        chk("reset_dropping",  64'(o_dropping),  64'd0);
        rst = 1'b0;

        // OFF straight out of reset
        for (int i = 0; i < 10; i++) send_pkt(3, 1'b0, 1'b0, dr);
        cnt_chk("off");
        chk("off_total_const", 64'(ov_pkt_total), 64'd10);

        do_cfg(2'd1, 16'd4, 8'd0, 16'd0, 16'd0);
        for (int i = 0; i < 12; i++) begin send_pkt(1, 1'b0, 1'b0, dr); pat12[i] = dr; end
        chk("periodic_pattern", 64'(pat12), 64'(12'b1000_1000_1000));
        cnt_chk("periodic");
        chk("periodic_dropped_const", 64'(ov_pkt_dropped), 64'd3);

        do_cfg(2'd2, 16'd2, 8'd3, 16'd0, 16'd0);
        for (int i = 0; i < 10; i++) begin
            send_pkt(int'($urandom_range(1, 3)), 1'b1, 1'b0, dr);
            pat10[i] = dr;
        end
        chk("burst_pattern", 64'(pat10), 64'(10'b11100_11100));
        cnt_chk("burst");

        do_cfg(2'd3, 16'd0, 8'd0, 16'h8000, 16'h0000);
        for (int i = 0; i < 1000; i++) send_pkt(1, 1'b1, 1'b0, dr);
        cnt_chk("random");

        t_th[6] = 16'($urandom);
        for (int c = 0; c < 8; c++) begin
            do_cfg(t_mode[c], t_n[c], t_b[c], t_th[c], (c == 6) ? 16'($urandom) : 16'h1234);
            for (int i = 0; i < 20; i++) send_pkt(int'($urandom_range(1, 4)), 1'b1, 1'b0, dr);
            cnt_chk("table");
        end

        do_cfg(2'd1, 16'd1, 8'd0, 16'd0, 16'd0);
        for (int i = 0; i < 1030; i++) send_pkt(1, 1'b0, 1'b0, dr);
        chk("sat_total",   64'(ov_pkt_total),   64'(CMAX));
        chk("sat_dropped", 64'(ov_pkt_dropped), 64'(CMAX));
        cnt_chk("sat");

        // Load together with a start beat: old config (drop all) decides that packet.
        do_cfg(2'd1, 16'd1, 8'd0, 16'd0, 16'd0);
        cfg_mode = 2'd0; cfg_period = 16'd0;
        send_pkt(1, 1'b0, 1'b1, dr);
        chk("load_pkt_dropped", 64'(dr), 64'd1);
        chk("load_total_const", 64'(ov_pkt_total), 64'd0);
        cnt_chk("load");
        send_pkt(2, 1'b0, 1'b0, dr);
        chk("after_load_pass", 64'(dr), 64'd0);
        chk("after_load_total", 64'(ov_pkt_total), 64'd1);
        cnt_chk("after_load");

        // Reset lands on beat 2 of a 4-beat packet; beats 3 and 4 become orphans.
        do_cfg(2'd0, 16'd0, 8'd0, 16'd0, 16'd0);
        @(negedge clk);
        in_valid = 1'b1; in_start = 1'b1; in_last = 1'b0; in_head = 8'h11; in_data = 16'h2222;
        #2; beat_chk("mid_b1", 1'b0);
        @(posedge clk); m_commit(1'b0);
        @(negedge clk);
        in_start = 1'b0; in_head = 8'h33; in_data = 16'h4444; rst = 1'b1;
        #2; beat_chk("mid_b2", 1'b0);
        @(posedge clk); m_load(0, 0, 0, 0, 16'h0);
        for (int b = 3; b <= 4; b++) begin
            @(negedge clk);
            rst = 1'b0; in_last = (b == 4); in_head = 8'(b); in_data = 16'(b * 7);
            #2; beat_chk("orphan", 1'b1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        cnt_chk("orphan");
        send_pkt(2, 1'b0, 1'b0, dr);
        chk("post_rst_pass", 64'(dr), 64'd0);
        chk("post_rst_total", 64'(ov_pkt_total), 64'd1);
        cnt_chk("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
